ble_sniff_scheduler: RTL and testbench

//  Sequences the BLE packet sniffer across advertising channels 37/38/39, or holds one fixed channel.
//  - Drives sniffer enable and channel; dwells a programmed number of symbols per channel.
//  - Edge-detects the sniffer's level-type packet-detected flag and captures length + channel.
//  - Presents each capture on a 1-entry valid/ready report port; counts overflow drops.

---
 rtl/ble_sniff_pkg.sv | 23 ++
 rtl/ble_sniff_scheduler_if.sv | 24 ++
 rtl/ble_sniff_report_slot.sv | 63 ++++++
 rtl/ble_sniff_scheduler.sv | 161 ++++++++++++++++
 tb/tb_ble_sniff_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ble_sniff_pkg.sv
// Shared types and constants for the BLE sniff scheduler: FSM states,
// advertising channel numbers, and report field widths.
package ble_sniff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TUNE,
        LISTEN
    } state_t;

    localparam logic [5:0] ADV_CH_37 = 6'd37;
    localparam logic [5:0] ADV_CH_38 = 6'd38;
    localparam logic [5:0] ADV_CH_39 = 6'd39;

    localparam int LEN_W = 9;
    localparam int CH_W  = 6;

    // Hop order is A -> B -> C -> A.
    function automatic logic [1:0] next_hop_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/ble_sniff_scheduler_if.sv
// Report port of the sniff scheduler: one captured packet (length + channel)
// offered with a valid/ready handshake.
interface ble_sniff_scheduler_if;

    logic                           rpt_valid;
    logic                           rpt_ready;
    logic [ble_sniff_pkg::LEN_W-1:0] rpt_len;
    logic [ble_sniff_pkg::CH_W-1:0]  rpt_channel;

    modport master (
        output rpt_valid,
        output rpt_len,
        output rpt_channel,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_len,
        input  rpt_channel,
        output rpt_ready
    );

endinterface

// File: rtl/ble_sniff_report_slot.sv
// Single-entry report register with valid/ready output and a saturating
// counter of captures lost because the entry was still occupied.
module ble_sniff_report_slot
    import ble_sniff_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              symbol_clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [LEN_W-1:0]  cap_len,
    input  logic [CH_W-1:0]   cap_channel,
    input  logic              rpt_ready,
    output logic              rpt_valid,
    output logic [LEN_W-1:0]  rpt_len,
    output logic [CH_W-1:0]   rpt_channel,
    output logic [DROP_W-1:0] drop_cnt
);

    logic              valid_q, valid_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [CH_W-1:0]   ch_q,    ch_d;
    logic [DROP_W-1:0] drop_q,  drop_d;

    always_comb begin
        valid_d = valid_q;
        len_d   = len_q;
        ch_d    = ch_q;
        drop_d  = drop_q;
        if (capture) begin
            // A report being accepted this cycle frees the slot for the new one.
            if (!valid_q || rpt_ready) begin
                valid_d = 1'b1;
                len_d   = cap_len;
                ch_d    = cap_channel;
            end else if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (valid_q && rpt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge symbol_clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            len_q   <= '0;
            ch_q    <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            len_q   <= len_d;
            ch_q    <= ch_d;
            drop_q  <= drop_d;
        end
    end

    assign rpt_valid   = valid_q;
    assign rpt_len     = len_q;
    assign rpt_channel = ch_q;
    assign drop_cnt    = drop_q;

endmodule

// File: rtl/ble_sniff_scheduler.sv
// Steps the packet sniffer through the advertising channels (or one fixed
// channel), with a settle gap before every dwell, and captures detected packets.
module ble_sniff_scheduler
    import ble_sniff_pkg::*;
#(
    parameter int              DWELL_W       = 16,
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [CH_W-1:0] CH_A          = ADV_CH_37,
    parameter logic [CH_W-1:0] CH_B          = ADV_CH_38,
    parameter logic [CH_W-1:0] CH_C          = ADV_CH_39,
    parameter int              DROP_W        = 8
) (
    input  logic                  symbol_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hop_en,
    input  logic [CH_W-1:0]       fixed_channel,
    input  logic [DWELL_W-1:0]    dwell_len,
    output logic                  sniff_en,
    output logic [CH_W-1:0]       sniff_channel,
    input  logic                  pkt_detected,
    input  logic [LEN_W-1:0]      pkt_len,
    ble_sniff_scheduler_if.master rpt,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  busy
);

    localparam int              SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0] HOP_LIST [3] = '{CH_A, CH_B, CH_C};

    logic [CH_W-1:0] hop_ch [3];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hop
            assign hop_ch[gi] = HOP_LIST[gi];
        end
    endgenerate

    state_t             state_q,     state_d;
    logic               hop_q,       hop_d;
    logic [CH_W-1:0]    fixed_q,     fixed_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    logic [1:0]         idx_q,       idx_d;
    logic [SET_W-1:0]   settle_q,    settle_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               sniff_en_q,  sniff_en_d;
    logic [CH_W-1:0]    sniff_ch_q,  sniff_ch_d;
    logic               busy_q,      busy_d;
    logic               pkt_q;
    logic [1:0]         idx_nxt;
    logic               capture;

    assign idx_nxt = next_hop_idx(idx_q);

    always_comb begin
        state_d     = state_q;
        hop_d       = hop_q;
        fixed_d     = fixed_q;
        dwell_d     = dwell_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        dwell_cnt_d = dwell_cnt_q;
        sniff_ch_d  = sniff_ch_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        hop_d      = hop_en;
                        fixed_d    = fixed_channel;
                        dwell_d    = (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
                        idx_d      = 2'd0;
                        sniff_ch_d = hop_en ? hop_ch[0] : fixed_channel;
                        settle_d   = SETTLE_LOAD;
                        state_d    = TUNE;
                    end
                end
                TUNE: begin
                    if (settle_q == '0) begin
                        state_d     = LISTEN;
                        dwell_cnt_d = dwell_q;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                LISTEN: begin
                    // The channel only ever changes on the way into TUNE, so it
                    // is never touched while the sniffer is enabled.
                    if (dwell_cnt_q == DWELL_W'(1)) begin
                        state_d  = TUNE;
                        settle_d = SETTLE_LOAD;
                        if (hop_q) begin
                            idx_d      = idx_nxt;
                            sniff_ch_d = hop_ch[idx_nxt];
                        end else begin
                            sniff_ch_d = fixed_q;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        sniff_en_d = (state_d == LISTEN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge symbol_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hop_q       <= 1'b0;
            fixed_q     <= '0;
            dwell_q     <= '0;
            idx_q       <= 2'd0;
            settle_q    <= '0;
            dwell_cnt_q <= '0;
            sniff_en_q  <= 1'b0;
            sniff_ch_q  <= CH_A;
            busy_q      <= 1'b0;
            pkt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hop_q       <= hop_d;
            fixed_q     <= fixed_d;
            dwell_q     <= dwell_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            dwell_cnt_q <= dwell_cnt_d;
            sniff_en_q  <= sniff_en_d;
            sniff_ch_q  <= sniff_ch_d;
            busy_q      <= busy_d;
            pkt_q       <= pkt_detected;
        end
    end

    // Edge seen on the dwell's last cycle still reports the channel being left.
    assign capture = pkt_detected && !pkt_q && (state_q == LISTEN);

    ble_sniff_report_slot #(
        .DROP_W (DROP_W)
    ) u_slot (
        .symbol_clk  (symbol_clk),
        .rst         (rst),
        .capture     (capture),
        .cap_len     (pkt_len),
        .cap_channel (sniff_ch_q),
        .rpt_ready   (rpt.rpt_ready),
        .rpt_valid   (rpt.rpt_valid),
        .rpt_len     (rpt.rpt_len),
        .rpt_channel (rpt.rpt_channel),
        .drop_cnt    (drop_cnt)
    );

    assign sniff_en      = sniff_en_q;
    assign sniff_channel = sniff_ch_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ble_sniff_scheduler.sv
// Directed bench for the sniff scheduler: hop timing, capture, overflow
// saturation, same-cycle accept, dwell-boundary capture, stop and reset.
module tb_ble_sniff_scheduler;

    logic       symbol_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hop_en = 1'b0;
    logic [5:0] fixed_channel = 6'd0;
    logic [15:0] dwell_len = 16'd0;
    logic       sniff_en;
    logic [5:0] sniff_channel;
    logic       pkt_detected = 1'b0;
    logic [8:0] pkt_len = 9'd0;
    logic [7:0] drop_cnt;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int hop_tab [3] = '{37, 38, 39};

    ble_sniff_scheduler_if rpt_if ();

    ble_sniff_scheduler dut (
        .symbol_clk    (symbol_clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .hop_en        (hop_en),
        .fixed_channel (fixed_channel),
        .dwell_len     (dwell_len),
        .sniff_en      (sniff_en),
        .sniff_channel (sniff_channel),
        .pkt_detected  (pkt_detected),
        .pkt_len       (pkt_len),
        .rpt           (rpt_if),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 symbol_clk = ~symbol_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge symbol_clk);
        #1;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench at the first TUNE sample after start (phase k=0).
    task automatic restart(input logic h, input logic [5:0] ch, input logic [15:0] dw);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        hop_en = h;
        fixed_channel = ch;
        dwell_len = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rpt_if.rpt_ready = 1'b0;
        adv(3);
        chk("rst_en", sniff_en, 0);
        chk("rst_ch", sniff_channel, 37);
        chk("rst_valid", rpt_if.rpt_valid, 0);
        chk("rst_len", rpt_if.rpt_len, 0);
        chk("rst_rch", rpt_if.rpt_channel, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Hop pattern: 2 tune samples then 4 listen samples per channel.
        restart(1'b1, 6'd0, 16'd4);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("t1_k%0d_en_ch", k), {sniff_en, sniff_channel},
                {((k % 6) >= 2) ? 1'b1 : 1'b0, 6'(hop_tab[(k / 6) % 3])});
            tick();
        end

        // dwell_len of zero behaves as a one-symbol dwell.
        restart(1'b0, 6'd12, 16'd0);
        adv(2);
        chk("t1b_en_k2", {sniff_en, sniff_channel}, {1'b1, 6'd12});
        tick();
        chk("t1b_en_k3", sniff_en, 0);

        // Single report from a 3-cycle level pulse on channel 38.
        restart(1'b1, 6'd0, 16'd4);
        adv(8);
        chk("t2_listen38", {sniff_en, sniff_channel}, {1'b1, 6'd38});
        pkt_detected = 1'b1;
        pkt_len = 9'd128;
        tick();
        chk("t2_valid", rpt_if.rpt_valid, 1);
        chk("t2_len", rpt_if.rpt_len, 128);
        chk("t2_ch", rpt_if.rpt_channel, 38);
        adv(2);
        pkt_detected = 1'b0;
        tick();
        chk("t2_one_rpt_drop", drop_cnt, 0);
        adv(3);
        chk("t2_held_valid", rpt_if.rpt_valid, 1);
        chk("t2_held_len", rpt_if.rpt_len, 128);
        rpt_if.rpt_ready = 1'b1;
        tick();
        chk("t2_consumed", rpt_if.rpt_valid, 0);
        rpt_if.rpt_ready = 1'b0;

        // Same-cycle accept and new capture, on fixed channel 5.
        restart(1'b0, 6'd5, 16'd1000);
        adv(2);
        pkt_detected = 1'b1;
        pkt_len = 9'd100;
        tick();
        chk("t4_first_len", rpt_if.rpt_len, 100);
        chk("t4_first_ch", rpt_if.rpt_channel, 5);
        pkt_detected = 1'b0;
        tick();
        pkt_detected = 1'b1;
        pkt_len = 9'd200;
        rpt_if.rpt_ready = 1'b1;
        tick();
        chk("t4_valid", rpt_if.rpt_valid, 1);
        chk("t4_len", rpt_if.rpt_len, 200);
        chk("t4_drop", drop_cnt, 0);
        rpt_if.rpt_ready = 1'b0;
        pkt_detected = 1'b0;
        tick();

        // 300 captures into a full slot: drops saturate at 255.
        for (int i = 0; i < 300; i++) begin
            pkt_detected = 1'b1;
            pkt_len = 9'(i);
            tick();
            pkt_detected = 1'b0;
            tick();
            if (i == 254) chk("t3_drop_255", drop_cnt, 255);
        end
        chk("t3_drop_sat", drop_cnt, 255);
        chk("t3_valid", rpt_if.rpt_valid, 1);
        chk("t3_len", rpt_if.rpt_len, 200);
        chk("t3_ch", rpt_if.rpt_channel, 5);

        // Edge in TUNE is ignored; edge on final dwell symbol of ch39 reports 39.
        rpt_if.rpt_ready = 1'b1;
        restart(1'b1, 6'd0, 16'd4);
        chk("t5_flushed", rpt_if.rpt_valid, 0);
        rpt_if.rpt_ready = 1'b0;
        pkt_detected = 1'b1;
        pkt_len = 9'd77;
        tick();
        pkt_detected = 1'b0;
        chk("t5_tune_ignored", rpt_if.rpt_valid, 0);
        adv(16);
        chk("t5_last39", {sniff_en, sniff_channel}, {1'b1, 6'd39});
        pkt_detected = 1'b1;
        pkt_len = 9'd55;
        tick();
        pkt_detected = 1'b0;
        chk("t5_rpt_ch", rpt_if.rpt_channel, 39);
        chk("t5_rpt_len", rpt_if.rpt_len, 55);
        chk("t5_next_ch", {sniff_en, sniff_channel}, {1'b0, 6'd37});

        // Stop mid-LISTEN keeps the report; reset mid-TUNE clears everything.
        adv(3);
        chk("t6_listen", sniff_en, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t6_stop_en", sniff_en, 0);
        chk("t6_stop_busy", busy, 0);
        chk("t6_kept_valid", rpt_if.rpt_valid, 1);
        chk("t6_kept_ch", rpt_if.rpt_channel, 39);
        hop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_tune_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_en", sniff_en, 0);
        chk("t6_rst_ch", sniff_channel, 37);
        chk("t6_rst_valid", rpt_if.rpt_valid, 0);
        chk("t6_rst_len", rpt_if.rpt_len, 0);
        chk("t6_rst_rch", rpt_if.rpt_channel, 0);
        chk("t6_rst_drop", drop_cnt, 0);
        chk("t6_rst_busy", busy, 0);
        rst = 1'b0;
        adv(3);
        chk("t6_stays_idle", {busy, sniff_en}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
